// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample/hold, DAC trial codes, comparator
// strobe, 2-flop synchronized decision capture, MSB-first binary search.
module sar_adc_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample,
  output logic             cmp_latch,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // WAIT needs a 2-cycle count, so the counter covers at least 0..1
  localparam int unsigned CNT_MAX =
    (SAMPLE_CYCLES > SETTLE_CYCLES) ? ((SAMPLE_CYCLES > 2) ? SAMPLE_CYCLES : 2)
                                    : ((SETTLE_CYCLES > 2) ? SETTLE_CYCLES : 2);
  localparam int unsigned CNT_W = $clog2(CNT_MAX);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_STROBE = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_cmp_s1;
  logic             r_cmp_s2;
  logic             r_sample;
  logic             r_cmp_latch;
  logic [WIDTH-1:0] r_dac_code;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_dac_next;

  // Resolve the current bit from the synchronized decision and arm the next one
  always_comb begin
    w_dac_next = r_dac_code;
    if (!r_cmp_s2) w_dac_next[r_idx] = 1'b0;
    if (r_idx != '0) w_dac_next[r_idx - IDX_W'(1)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= IDX_W'(WIDTH - 1);
      r_cmp_s1    <= 1'b0;
      r_cmp_s2    <= 1'b0;
      r_sample    <= 1'b0;
      r_cmp_latch <= 1'b0;
      r_dac_code  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_cmp_s1    <= cmp_in;
      r_cmp_s2    <= r_cmp_s1;
      r_cmp_latch <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dac_code <= '0;
          if (start) begin
            r_state  <= S_SAMPLE;
            r_sample <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
          end
        end
        S_SAMPLE: begin
          if (r_cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
            r_state    <= S_SETTLE;
            r_sample   <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= IDX_W'(WIDTH - 1);
            r_dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            r_state     <= S_STROBE;
            r_cmp_latch <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STROBE: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_dac_code <= w_dac_next;
            r_cnt      <= '0;
            if (r_idx == '0) begin
              r_state  <= S_DONE;
              r_result <= w_dac_next;
              r_done   <= 1'b1;
            end else begin
              r_state <= S_SETTLE;
              r_idx   <= r_idx - IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_dac_code <= '0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_sample   <= 1'b0;
          r_busy     <= 1'b0;
          r_dac_code <= '0;
        end
      endcase
    end
  end

  assign sample    = r_sample;
  assign cmp_latch = r_cmp_latch;
  assign dac_code  = r_dac_code;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal comparator model (vin >= dac_code).
module tb_sar_adc_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] vin   = 8'h00;
  logic       cmp_in;
  logic       sample;
  logic       cmp_latch;
  logic [7:0] dac_code;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  int         done_cyc, n_done, n_latch, latch_wide, busy_bad, sample_bad;
  logic       prev_latch;
  logic [7:0] trials [8];

  sar_adc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmp_in    (cmp_in),
    .sample    (sample),
    .cmp_latch (cmp_latch),
    .dac_code  (dac_code),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  assign cmp_in = (vin >= dac_code);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One conversion; cycle k is observed at the negedge after the (k-1)th rising edge
  task automatic convert(input logic [7:0] v, input int xa, input int xb);
    vin        = v;
    done_cyc   = -1;
    n_done     = 0;
    n_latch    = 0;
    latch_wide = 0;
    busy_bad   = 0;
    sample_bad = 0;
    prev_latch = 1'b0;
    for (int i = 0; i < 8; i++) trials[i] = 8'hxx;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      start = (k == xa) || (k == xb);
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (cmp_latch) begin
        if (n_latch < 8) trials[n_latch] = dac_code;
        n_latch++;
        if (prev_latch) latch_wide++;
      end
      prev_latch = cmp_latch;
      if (busy !== (k <= 43)) busy_bad++;
      if (sample !== (k <= 2)) sample_bad++;
    end
    start = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] exp_ff [8];
    logic [7:0] exp_5a [8];
    logic [7:0] r1, r2;
    int d1, d2, dn_rst;
    exp_ff = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    exp_5a = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_latch", 32'(cmp_latch), 32'd0);
    chk("rst_dac", 32'(dac_code), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal conversion with latency and waveform shape
    convert(8'hA5, 0, 0);
    chk("a5_done_cycle", 32'(done_cyc), 32'd43);
    chk("a5_done_count", 32'(n_done), 32'd1);
    chk("a5_result", 32'(result), 32'hA5);
    chk("a5_busy_shape", 32'(busy_bad), 32'd0);
    chk("a5_sample_shape", 32'(sample_bad), 32'd0);
    chk("a5_latch_count", 32'(n_latch), 32'd8);
    chk("a5_latch_width", 32'(latch_wide), 32'd0);
    chk("a5_idle_dac", 32'(dac_code), 32'd0);

    // Corner codes
    convert(8'h00, 0, 0);
    chk("00_result", 32'(result), 32'h00);
    chk("00_done_cycle", 32'(done_cyc), 32'd43);
    convert(8'hFF, 0, 0);
    chk("ff_result", 32'(result), 32'hFF);
    for (int i = 0; i < 8; i++) chk($sformatf("ff_trial%0d", i), 32'(trials[i]), 32'(exp_ff[i]));

    // Trial sequence for 0x5A
    convert(8'h5A, 0, 0);
    chk("5a_result", 32'(result), 32'h5A);
    chk("5a_latch_count", 32'(n_latch), 32'd8);
    chk("5a_latch_width", 32'(latch_wide), 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("5a_trial%0d", i), 32'(trials[i]), 32'(exp_5a[i]));

    // Extra start pulses during a conversion are ignored
    convert(8'h96, 5, 20);
    chk("xs_done_count", 32'(n_done), 32'd1);
    chk("xs_done_cycle", 32'(done_cyc), 32'd43);
    chk("xs_result", 32'(result), 32'h96);
    chk("xs_busy_shape", 32'(busy_bad), 32'd0);

    // start held high: back-to-back conversions
    repeat (2) @(negedge clk);
    vin = 8'h33;
    d1 = -1;
    d2 = -1;
    r1 = 8'hxx;
    r2 = 8'hxx;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          r1 = result;
          vin = 8'hC4;
        end else if (d2 < 0) begin
          d2 = k;
          r2 = result;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_cycle", 32'(d1), 32'd43);
    chk("b2b_spacing", 32'(d2 - d1), 32'd44);
    chk("b2b_result1", 32'(r1), 32'h33);
    chk("b2b_result2", 32'(r2), 32'hC4);

    // Reset mid-conversion
    convert(8'h77, 0, 0);
    chk("pre_rst_result", 32'(result), 32'h77);
    vin = 8'hE1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_sample", 32'(sample), 32'd0);
    chk("mr_latch", 32'(cmp_latch), 32'd0);
    chk("mr_dac", 32'(dac_code), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_result", 32'(result), 32'd0);
    dn_rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) dn_rst++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) dn_rst++;
    end
    chk("mr_no_done", 32'(dn_rst), 32'd0);
    chk("mr_still_idle", 32'(busy), 32'd0);
    convert(8'h3C, 0, 0);
    chk("post_rst_result", 32'(result), 32'h3C);
    chk("post_rst_done_cycle", 32'(done_cyc), 32'd43);
    chk("post_rst_done_count", 32'(n_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller that sits on the output side of the latched comparator. It drives the capacitive or resistive DAC code and the sample/hold switch, and strobes the comparator. It captures each comparator decision through a 2-flop synchronizer and resolves one bit per step, MSB first, then publishes a WIDTH-bit result with a done pulse.

Parameters:
WIDTH, 8, resolution in bits (>=2)
SAMPLE_CYCLES, 2, cycles the sample switch is held closed (>=1)
SETTLE_CYCLES, 2, cycles the DAC is allowed to settle before each comparator strobe (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level request to begin a conversion; sampled only in IDLE
cmp_in  in  1  comparator output (1 = input above DAC level); asynchronous, synchronized internally
sample  out  1  sample/hold switch enable
cmp_latch  out  1  one-cycle comparator strobe
dac_code  out  WIDTH  trial code driving the DAC
busy  out  1  high from the cycle after start is accepted until DONE completes
done  out  1  one-cycle pulse when result is updated
result  out  WIDTH  last completed conversion; holds until the next DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE. sample, cmp_latch, busy and done = 0. dac_code and result = 0. Synchronizer flops = 0. Bit index = WIDTH-1.
- All outputs are registered; none is combinational from inputs.
- FSM states and transitions:
  - IDLE: busy=0, dac_code=0. If start=1 at a rising edge, go to SAMPLE.
  - SAMPLE: sample=1, busy=1, dac_code=0. Hold for SAMPLE_CYCLES cycles. On exit, dac_code = 1<<(WIDTH-1) and bit index = WIDTH-1; go to SETTLE.
  - SETTLE: hold for SETTLE_CYCLES cycles with dac_code stable, then go to STROBE.
  - STROBE: cmp_latch=1 for exactly 1 cycle, then go to WAIT.
  - WAIT: 2 cycles, covering synchronizer latency. At the end of the 2nd cycle, read the synchronized compare value:
    - If it is 0, clear dac_code[idx]; otherwise keep it.
    - If idx>0, also set dac_code[idx-1], decrement idx, and go to SETTLE.
    - If idx=0, go to DONE.
  - DONE: result <= dac_code (final), done=1 for 1 cycle, busy=1. Next state is IDLE with dac_code cleared to 0.
- Latency: with start sampled at edge 0, done is high in cycle N = SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+3) + 1. For the defaults this is 2 + 8*5 + 1 = 43.
- start asserted while busy is ignored; it is not queued.
- If start is held high continuously, the block enters SAMPLE on the edge leaving IDLE. Back-to-back conversions are therefore spaced by exactly 1 IDLE cycle.
- cmp_in is only consumed at the end of WAIT; changes at any other time have no effect.
- Reset asserted mid-conversion: immediate return to reset values. result is cleared to 0 and no done pulse is issued.
- Arithmetic: no carries; each step is a bit set or clear only, so dac_code never exceeds 2^WIDTH-1.

Test Plan:
- Comparator model cmp_in = (vin >= dac_code), defaults, vin=0xA5, single start pulse -> done pulses once at cycle 43; result=0xA5; busy high cycles 1..43.
- Corner codes vin=0x00 and vin=0xFF -> result 0x00 and 0xFF respectively. The dac_code trial sequence for 0xFF is 0x80, 0xC0, 0xE0, …, 0xFF.
- Trial sequence for vin=0x5A -> observed dac_code per step: 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B; final result=0x5A. cmp_latch pulses exactly 8 times, each 1 cycle wide.
- Extra start pulses at cycles 5 and 20 during a conversion -> ignored; exactly one done pulse; result matches the first vin.
- start held high with vin changing 0x33 then 0xC4 between conversions -> done pulses 44 cycles apart; results are 0x33 then 0xC4.
- rst_n pulled low at cycle 20 of a conversion with result previously 0x77 -> all outputs go to 0 immediately with no done pulse. A new start after release converts normally.
